alien_formation: RTL and testbench

Parametrised grid of ROWS×COLS aliens that march as one block across the playfield. It generalises the single-alien sprite:
- per-cell alive mask, indexed hit input;
- edge reversal computed from the live extents of the formation, not its full footprint;
- march cadence that speeds up as aliens die;
- cleared/landed status for game control.

It sits between the collision detector (hit source) and the pixel mixer (RGB + active), on `pixel_clk`, stepping on `fsync`.

---
 rtl/alien_formation_pkg.sv | 34 +++
 rtl/alien_formation_extent.sv | 58 +++++
 rtl/alien_formation.sv | 185 ++++++++++++++++++
 tb/tb_alien_formation.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_formation_pkg.sv
// ============================================================================
// Module  : alien_formation_pkg
// Brief   : Shared playfield/enemy constants, formation defaults and state type
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alien_formation_pkg;

  localparam int HRES        = 640;
  localparam int ENEMY_W     = 16;
  localparam int ENEMY_H     = 16;
  localparam int ENEMY_SPEED = 4;
  localparam int DROP        = 16;
  localparam logic [23:0] ENEMY_COLOR = 24'h40_E0_40;

  localparam int DEF_PITCH_X = ENEMY_W + 16;
  localparam int DEF_PITCH_Y = ENEMY_H + 12;
  localparam int DEF_LAND_Y  = 400;

  typedef enum logic [1:0] {
    MARCH   = 2'd0,
    CLEARED = 2'd1,
    LANDED  = 2'd2
  } alien_state_t;

  // Pixel offset of a row/column index; pitches are constants, so this is a constant multiply
  function automatic logic signed [11:0] cell_offset(input logic [2:0] idx, input int pitch);
    return 12'(int'(idx) * pitch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alien_formation_extent.sv
// ============================================================================
// Module  : formation_extent
// Brief   : Live-cell extents (columns/rows) and popcount of the alive mask
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module formation_extent
  import alien_formation_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 6
)(
  input  logic [ROWS*COLS-1:0] alive_mask,
  output logic [2:0]           lcol,
  output logic [2:0]           rcol,
  output logic [2:0]           trow,
  output logic [2:0]           brow,
  output logic [6:0]           alive_count
);

  logic [ROWS-1:0] w_row_any;
  logic [COLS-1:0] w_col_any;

  always_comb begin
    w_row_any   = '0;
    w_col_any   = '0;
    alive_count = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_mask[r*COLS + c]) begin
          w_row_any[r] = 1'b1;
          w_col_any[c] = 1'b1;
        end
        alive_count = alive_count + 7'(alive_mask[r*COLS + c]);
      end
    end
  end

  // Descending scan leaves the lowest index, ascending leaves the highest
  always_comb begin
    lcol = '0;
    rcol = '0;
    trow = '0;
    brow = '0;
    for (int c = COLS-1; c >= 0; c--)
      if (w_col_any[c]) lcol = 3'(c);
    for (int c = 0; c < COLS; c++)
      if (w_col_any[c]) rcol = 3'(c);
    for (int r = ROWS-1; r >= 0; r--)
      if (w_row_any[r]) trow = 3'(r);
    for (int r = 0; r < ROWS; r++)
      if (w_row_any[r]) brow = 3'(r);
  end

endmodule

`default_nettype wire

// File: rtl/alien_formation.sv
// ============================================================================
// Module  : alien_formation
// Brief   : ROWS x COLS alien block marching on fsync, with hits, cadence and end states
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alien_formation
  import alien_formation_pkg::*;
#(
  parameter int ROWS         = 3,
  parameter int COLS         = 6,
  parameter int PITCH_X      = DEF_PITCH_X,
  parameter int PITCH_Y      = DEF_PITCH_Y,
  parameter int START_X      = 100,
  parameter int START_Y      = 60,
  parameter int LAND_Y       = DEF_LAND_Y,
  parameter int PERIOD_SHIFT = 2
)(
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  fsync,
  input  logic signed [11:0]    hpos,
  input  logic signed [11:0]    vpos,
  input  logic                  hit_valid,
  input  logic [2:0]            hit_row,
  input  logic [2:0]            hit_col,
  output logic [7:0]            pixel [0:2],
  output logic                  active,
  output logic [2:0]            pix_row,
  output logic [2:0]            pix_col,
  output logic [ROWS*COLS-1:0]  alive_mask,
  output logic [6:0]            alive_count,
  output logic signed [11:0]    lhpos,
  output logic signed [11:0]    rhpos,
  output logic signed [11:0]    tvpos,
  output logic signed [11:0]    bvpos,
  output logic                  cleared,
  output logic                  landed
);

  localparam int N = ROWS * COLS;

  logic signed [11:0] r_org_x, r_org_y;
  logic               r_dir, r_dropped, r_cleared, r_landed;
  logic [6:0]         r_frame_cnt;
  logic [N-1:0]       r_alive_mask;
  alien_state_t       r_state;
  logic signed [11:0] r_hold_lhpos, r_hold_rhpos, r_hold_tvpos, r_hold_bvpos;

  logic [N-1:0]       w_kill, w_mask_next;
  logic [2:0]         w_lcol, w_rcol, w_trow, w_brow;
  logic [6:0]         w_alive_count, w_step_thresh;
  logic signed [11:0] w_lhpos, w_rhpos, w_tvpos, w_bvpos;
  logic               w_empty;

  formation_extent #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_extent (
    .alive_mask  (r_alive_mask),
    .lcol        (w_lcol),
    .rcol        (w_rcol),
    .trow        (w_trow),
    .brow        (w_brow),
    .alive_count (w_alive_count)
  );

  // Out-of-range indices match no cell; a dead cell simply stays dead
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < N; i++)
      if (hit_valid && int'(hit_row) < ROWS && int'(hit_col) < COLS &&
          (int'(hit_row) * COLS + int'(hit_col)) == i)
        w_kill[i] = 1'b1;
  end

  assign w_mask_next   = r_alive_mask & ~w_kill;
  assign w_empty       = (r_alive_mask == '0);
  assign w_step_thresh = w_alive_count >> PERIOD_SHIFT;

  assign w_lhpos = r_org_x + cell_offset(w_lcol, PITCH_X);
  assign w_rhpos = r_org_x + cell_offset(w_rcol, PITCH_X) + 12'(ENEMY_W);
  assign w_tvpos = r_org_y + cell_offset(w_trow, PITCH_Y);
  assign w_bvpos = r_org_y + cell_offset(w_brow, PITCH_Y) + 12'(ENEMY_H);

  // An empty mask has no meaningful extents, so show the last live box instead
  assign lhpos = w_empty ? r_hold_lhpos : w_lhpos;
  assign rhpos = w_empty ? r_hold_rhpos : w_rhpos;
  assign tvpos = w_empty ? r_hold_tvpos : w_tvpos;
  assign bvpos = w_empty ? r_hold_bvpos : w_bvpos;

  assign alive_mask  = r_alive_mask;
  assign alive_count = w_alive_count;
  assign cleared     = r_cleared;
  assign landed      = r_landed;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_org_x      <= 12'(START_X);
      r_org_y      <= 12'(START_Y);
      r_dir        <= 1'b0;
      r_frame_cnt  <= '0;
      r_alive_mask <= '1;
      r_state      <= MARCH;
      r_cleared    <= 1'b0;
      r_landed     <= 1'b0;
      r_dropped    <= 1'b0;
      r_hold_lhpos <= '0;
      r_hold_rhpos <= '0;
      r_hold_tvpos <= '0;
      r_hold_bvpos <= '0;
    end else begin
      r_alive_mask <= w_mask_next;
      r_dropped    <= 1'b0;
      if (!w_empty) begin
        r_hold_lhpos <= w_lhpos;
        r_hold_rhpos <= w_rhpos;
        r_hold_tvpos <= w_tvpos;
        r_hold_bvpos <= w_bvpos;
      end
      case (r_state)
        MARCH: begin
          if (w_mask_next == '0) begin
            r_state   <= CLEARED;
            r_cleared <= 1'b1;
          end else if (r_dropped && w_bvpos >= 12'(LAND_Y)) begin
            r_state  <= LANDED;
            r_landed <= 1'b1;
          end else if (fsync) begin
            if (r_frame_cnt < w_step_thresh) begin
              r_frame_cnt <= r_frame_cnt + 7'd1;
            end else begin
              r_frame_cnt <= '0;
              if (!r_dir) begin
                if (w_rhpos + 12'(ENEMY_SPEED) < 12'(HRES)) begin
                  r_org_x <= r_org_x + 12'(ENEMY_SPEED);
                end else begin
                  r_org_y   <= r_org_y + 12'(DROP);
                  r_dir     <= 1'b1;
                  r_dropped <= 1'b1;
                end
              end else begin
                if (w_lhpos - 12'(ENEMY_SPEED) > 12'sd0) begin
                  r_org_x <= r_org_x - 12'(ENEMY_SPEED);
                end else begin
                  r_org_y   <= r_org_y + 12'(DROP);
                  r_dir     <= 1'b0;
                  r_dropped <= 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active  = 1'b0;
    pix_row = '0;
    pix_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!active && r_alive_mask[r*COLS + c] &&
            hpos >= r_org_x + cell_offset(3'(c), PITCH_X) &&
            hpos <= r_org_x + cell_offset(3'(c), PITCH_X) + 12'(ENEMY_W) &&
            vpos >= r_org_y + cell_offset(3'(r), PITCH_Y) &&
            vpos <= r_org_y + cell_offset(3'(r), PITCH_Y) + 12'(ENEMY_H)) begin
          active  = 1'b1;
          pix_row = 3'(r);
          pix_col = 3'(c);
        end
      end
    end
  end

  assign pixel[0] = active ? ENEMY_COLOR[23:16] : 8'h00;
  assign pixel[1] = active ? ENEMY_COLOR[15:8]  : 8'h00;
  assign pixel[2] = active ? ENEMY_COLOR[7:0]   : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_alien_formation.sv
// ============================================================================
// Module  : tb_alien_formation
// Brief   : Directed self-checking bench for alien_formation (3x6 default grid)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alien_formation;

  logic               pixel_clk = 1'b0;
  logic               rst = 1'b1;
  logic               fsync = 1'b0;
  logic signed [11:0] hpos = '0, vpos = '0;
  logic               hit_valid = 1'b0;
  logic [2:0]         hit_row = '0, hit_col = '0;
  logic [7:0]         pixel [0:2];
  logic               active;
  logic [2:0]         pix_row, pix_col;
  logic [17:0]        alive_mask;
  logic [6:0]         alive_count;
  logic signed [11:0] lhpos, rhpos, tvpos, bvpos;
  logic               cleared, landed;

  int n_assert = 0;
  int n_fail   = 0;
  int found;
  int frames;

  alien_formation dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .fsync       (fsync),
    .hpos        (hpos),
    .vpos        (vpos),
    .hit_valid   (hit_valid),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .pixel       (pixel),
    .active      (active),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .alive_mask  (alive_mask),
    .alive_count (alive_count),
    .lhpos       (lhpos),
    .rhpos       (rhpos),
    .tvpos       (tvpos),
    .bvpos       (bvpos),
    .cleared     (cleared),
    .landed      (landed)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic frame();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
  endtask

  task automatic hit(input int r, input int c);
    hit_valid = 1'b1;
    hit_row   = 3'(r);
    hit_col   = 3'(c);
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset and idle cadence: 18 alive -> one step per 5 frames
    do_reset();
    chk("rst_mask", alive_mask, 18'h3FFFF);
    chk("rst_count", alive_count, 18);
    chk("rst_lhpos", lhpos, 100);
    chk("rst_rhpos", rhpos, 276);
    chk("rst_tvpos", tvpos, 60);
    chk("rst_bvpos", bvpos, 132);
    chk("rst_cleared", cleared, 0);
    chk("rst_landed", landed, 0);
    repeat (4) frame();
    chk("idle4_lhpos", lhpos, 100);
    frame();
    chk("idle5_lhpos", lhpos, 104);
    repeat (3) frame();
    chk("idle8_lhpos", lhpos, 104);
    chk("idle8_mask", alive_mask, 18'h3FFFF);

    // ---- kill columns 4 and 5
    hit(0, 5);
    chk("hit1_mask", alive_mask, 18'h3FFDF);
    chk("hit1_count", alive_count, 17);
    hit(1, 5); hit(2, 5); hit(0, 4); hit(1, 4); hit(2, 4);
    chk("cols_mask", alive_mask, 18'h0F3CF);
    chk("cols_count", alive_count, 12);
    chk("cols_rhpos", rhpos, 216);
    chk("cols_lhpos", lhpos, 104);

    // ---- march to the narrowed right edge and reverse
    found  = 0;
    frames = 0;
    for (int f = 1; f <= 600 && found == 0; f++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      if (tvpos != 12'sd60) begin
        found  = 1;
        frames = f;
      end
      tick();
    end
    chk("rev_seen", found, 1);
    chk("rev_frame", frames, 421);
    chk("rev_tvpos", tvpos, 76);
    chk("rev_lhpos", lhpos, 524);
    chk("rev_rhpos", rhpos, 636);

    // ---- hit coincident with fsync: cadence decided by the pre-hit count
    frame();
    frame();
    chk("pre_coinc_lhpos", lhpos, 524);
    fsync     = 1'b1;
    hit_valid = 1'b1;
    hit_row   = 3'd0;
    hit_col   = 3'd3;
    tick();
    fsync     = 1'b0;
    hit_valid = 1'b0;
    chk("coinc_mask", alive_mask, 18'h0F3C7);
    chk("coinc_count", alive_count, 11);
    chk("coinc_lhpos", lhpos, 524);
    chk("coinc_rhpos", rhpos, 636);
    tick();
    frame();
    chk("left_step_lhpos", lhpos, 520);

    // ---- ignored hits, then clear the formation
    hit(5, 0);
    chk("oor_mask", alive_mask, 18'h0F3C7);
    hit(0, 5);
    chk("dead_mask", alive_mask, 18'h0F3C7);
    hit(0, 1); hit(0, 2);
    hit(1, 0); hit(1, 1); hit(1, 2); hit(1, 3);
    hit(2, 0); hit(2, 1); hit(2, 2); hit(2, 3);
    chk("last_mask", alive_mask, 18'h00001);
    chk("last_cleared", cleared, 0);
    chk("last_rhpos", rhpos, 536);
    chk("last_bvpos", bvpos, 92);
    hit(0, 0);
    chk("clr_cleared", cleared, 1);
    chk("clr_mask", alive_mask, 0);
    chk("clr_count", alive_count, 0);
    chk("clr_hold_lhpos", lhpos, 520);
    chk("clr_hold_bvpos", bvpos, 92);
    hpos = 12'sd520;
    vpos = 12'sd76;
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("clr_active", active, 0);
    end
    chk("clr_frozen_lhpos", lhpos, 520);
    chk("clr_landed", landed, 0);
    hpos = '0;
    vpos = '0;

    // ---- single survivor at (2,0) marches down until it lands
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++)
        if (!(r == 2 && c == 0)) hit(r, c);
    chk("solo_mask", alive_mask, 18'h01000);
    chk("solo_bvpos", bvpos, 132);
    found  = 0;
    frames = 0;
    for (int f = 1; f <= 3000 && found == 0; f++) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      if (bvpos >= 12'sd400) begin
        found  = 1;
        frames = f;
      end else begin
        tick();
      end
    end
    chk("land_seen", found, 1);
    chk("land_frame", frames, 2611);
    chk("land_bvpos", bvpos, 404);
    chk("land_pre_flag", landed, 0);
    tick();
    chk("land_flag", landed, 1);
    repeat (3) frame();
    chk("land_frozen_lhpos", lhpos, 620);
    chk("land_frozen_bvpos", bvpos, 404);
    chk("land_cleared", cleared, 0);

    // ---- reset from LANDED and pixel sweep around cell (1,2)
    do_reset();
    chk("rst2_landed", landed, 0);
    chk("rst2_mask", alive_mask, 18'h3FFFF);
    chk("rst2_lhpos", lhpos, 100);
    chk("rst2_tvpos", tvpos, 60);
    hpos = 12'sd164; vpos = 12'sd88; #1;
    chk("px_tl_active", active, 1);
    chk("px_tl_row", pix_row, 1);
    chk("px_tl_col", pix_col, 2);
    chk("px_tl_red", pixel[0], 8'h40);
    chk("px_tl_grn", pixel[1], 8'hE0);
    hpos = 12'sd180; vpos = 12'sd104; #1;
    chk("px_br_active", active, 1);
    chk("px_br_col", pix_col, 2);
    hpos = 12'sd181; vpos = 12'sd96; #1;
    chk("px_gapx_active", active, 0);
    chk("px_gapx_row", pix_row, 0);
    chk("px_gapx_blue", pixel[2], 0);
    hpos = 12'sd170; vpos = 12'sd105; #1;
    chk("px_gapy_active", active, 0);
    hpos = 12'sd163; vpos = 12'sd96; #1;
    chk("px_gapl_active", active, 0);
    hpos = '0; vpos = '0;

    // ---- reset mid-march with fsync and a hit pending
    repeat (5) frame();
    chk("mid_lhpos", lhpos, 104);
    repeat (2) frame();
    rst       = 1'b1;
    fsync     = 1'b1;
    hit_valid = 1'b1;
    hit_row   = 3'd0;
    hit_col   = 3'd0;
    tick();
    rst       = 1'b0;
    fsync     = 1'b0;
    hit_valid = 1'b0;
    chk("midrst_lhpos", lhpos, 100);
    chk("midrst_tvpos", tvpos, 60);
    chk("midrst_mask", alive_mask, 18'h3FFFF);
    chk("midrst_cleared", cleared, 0);
    repeat (4) frame();
    chk("midrst_4f_lhpos", lhpos, 100);
    frame();
    chk("midrst_5f_lhpos", lhpos, 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
